// File: rtl/bp_pkg.sv
// bp_pkg: shared types for the branch-predictor update scheduler.
package bp_pkg;
    localparam int PC_W = 64;
    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic            taken;
        logic [PC_W-1:0] target;
        logic            mispred;
    } bp_upd_t;
    typedef enum logic [1:0] {IDLE = 2'd0, SHARE = 2'd1, DRAIN = 2'd2} bp_sched_state_e;
endpackage

// File: rtl/bp_upd_fifo.sv
// bp_upd_fifo: circular FIFO of branch resolutions; head is always visible and held until dequeued.
module bp_upd_fifo
    import bp_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          enq_i,
    input  bp_upd_t       din_i,
    input  logic          deq_i,
    output bp_upd_t       head_o,
    output logic [CW-1:0] count_o
);
    localparam int PW = $clog2(DEPTH);
    bp_upd_t       mem_q [DEPTH];
    logic [PW-1:0] head_q, tail_q;
    logic [CW-1:0] count_q;
    always_ff @(posedge clock) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (enq_i) tail_q <= tail_q + 1'b1;
            if (deq_i) head_q <= head_q + 1'b1;
            count_q <= count_q + CW'(enq_i) - CW'(deq_i);
        end
    end
    always_ff @(posedge clock) begin
        if (enq_i) mem_q[tail_q] <= din_i;
    end
    assign head_o  = mem_q[head_q];
    assign count_o = count_q;
endmodule

// File: rtl/bp_update_sched.sv
// bp_update_sched: shares the single predictor-table port between fetch lookups and queued updates.
module bp_update_sched
    import bp_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            ex_br_valid,
    input  logic [PC_W-1:0] ex_pc_idx,
    input  logic            ex_br_res,
    input  logic [PC_W-1:0] target_pc,
    input  logic            btb_mispred,
    output logic            ex_stall,
    input  logic            if_lookup_req,
    output logic            if_lookup_gnt,
    output logic            upd_valid,
    output logic [PC_W-1:0] upd_pc,
    output logic            upd_taken,
    output logic [PC_W-1:0] upd_target,
    output logic            upd_wr_btb,
    output logic [CW-1:0]   upd_count
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    bp_sched_state_e state_q, state_d;
    logic [CW-1:0]   mp_q, mp_d, count_d;
    logic [SW-1:0]   starve_q, starve_d;
    bp_upd_t         head;
    logic            enq;
    bp_upd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock  (clock),
        .reset  (reset),
        .enq_i  (enq),
        .din_i  ('{ex_pc_idx, ex_br_res, target_pc, btb_mispred}),
        .deq_i  (upd_valid),
        .head_o (head),
        .count_o(upd_count)
    );
    // Outputs are forced quiet while reset is held, regardless of stale state.
    assign ex_stall      = reset && upd_count == CW'(DEPTH);
    assign enq           = ex_br_valid && !ex_stall;
    assign upd_valid     = reset && (state_q == DRAIN ||
                           (state_q == SHARE && (!if_lookup_req || starve_q == SW'(STARVE_MAX))));
    assign if_lookup_gnt = reset && if_lookup_req && !upd_valid;
    assign upd_pc        = head.pc;
    assign upd_taken     = head.taken;
    assign upd_target    = head.target;
    assign upd_wr_btb    = head.mispred;
    always_comb begin
        count_d  = upd_count + CW'(enq) - CW'(upd_valid);
        mp_d     = mp_q + CW'(enq && btb_mispred) - CW'(upd_valid && head.mispred);
        starve_d = (upd_valid || state_q == IDLE) ? '0 :
                   (state_q == SHARE && if_lookup_gnt && starve_q != SW'(STARVE_MAX)) ? starve_q + 1'b1 : starve_q;
        state_d  = count_d == '0 ? IDLE :
                   (mp_d != '0 || count_d == CW'(DEPTH)) ? DRAIN : SHARE;
    end
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= IDLE;
            mp_q     <= '0;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            mp_q     <= mp_d;
            starve_q <= starve_d;
        end
    end
endmodule

// File: tb/tb_bp_update_sched.sv
// tb_bp_update_sched: randomized bench with a queue-based reference model and head-entry scoreboard.
module tb_bp_update_sched;
    localparam int DEPTH = 4;
    localparam int SMAX  = 8;
    logic        clock = 1'b0;
    logic        reset;
    logic        ex_br_valid, ex_br_res, btb_mispred, if_lookup_req;
    logic [63:0] ex_pc_idx, target_pc;
    logic        ex_stall, if_lookup_gnt, upd_valid, upd_taken, upd_wr_btb;
    logic [63:0] upd_pc, upd_target;
    logic [2:0]  upd_count;
    typedef struct {
        logic [63:0] pc;
        logic        tk;
        logic [63:0] tg;
        logic        mp;
    } ent_t;
    ent_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   starve = 0;
    bp_update_sched #(.DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
        .clock        (clock),
        .reset        (reset),
        .ex_br_valid  (ex_br_valid),
        .ex_pc_idx    (ex_pc_idx),
        .ex_br_res    (ex_br_res),
        .target_pc    (target_pc),
        .btb_mispred  (btb_mispred),
        .ex_stall     (ex_stall),
        .if_lookup_req(if_lookup_req),
        .if_lookup_gnt(if_lookup_gnt),
        .upd_valid    (upd_valid),
        .upd_pc       (upd_pc),
        .upd_taken    (upd_taken),
        .upd_target   (upd_target),
        .upd_wr_btb   (upd_wr_btb),
        .upd_count    (upd_count)
    );
    always #5 clock = ~clock;
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask
    // Reference model: the FIFO is a plain queue; port arbitration follows the priority rules directly.
    always @(negedge clock) begin : model
        int   n;
        int   mps;
        bit   euv;
        bit   egnt;
        ent_t e;
        if (!reset) begin
            chk("reset_upd_valid", 64'(upd_valid), 64'(0));
            chk("reset_gnt", 64'(if_lookup_gnt), 64'(0));
            chk("reset_stall", 64'(ex_stall), 64'(0));
            q.delete();
            starve = 0;
        end else begin
            n   = q.size();
            mps = 0;
            foreach (q[i]) if (q[i].mp) mps++;
            euv  = n > 0 && (mps > 0 || n == DEPTH || !if_lookup_req || starve == SMAX);
            egnt = if_lookup_req && !euv;
            chk("count", 64'(upd_count), 64'(n));
            chk("stall", 64'(ex_stall), 64'(n == DEPTH));
            chk("upd_valid", 64'(upd_valid), 64'(euv));
            chk("gnt", 64'(if_lookup_gnt), 64'(egnt));
            if (euv) begin
                e = q.pop_front();
                if (upd_valid) begin
                    chk("upd_pc", upd_pc, e.pc);
                    chk("upd_taken", 64'(upd_taken), 64'(e.tk));
                    chk("upd_target", upd_target, e.tg);
                    chk("upd_wr_btb", 64'(upd_wr_btb), 64'(e.mp));
                end
            end
            starve = (euv || n == 0) ? 0 : (egnt && starve < SMAX) ? starve + 1 : starve;
            if (ex_br_valid && n != DEPTH)
                q.push_back('{ex_pc_idx, ex_br_res, target_pc, btb_mispred});
        end
    end
    task automatic step(input bit v, input bit mp, input bit rq, input bit rs = 1'b1);
        @(posedge clock);
        #1;
        reset         = rs;
        ex_br_valid   = v;
        btb_mispred   = mp;
        if_lookup_req = rq;
        ex_pc_idx     = {$urandom, $urandom};
        ex_br_res     = 1'($urandom);
        target_pc     = {$urandom, $urandom};
    endtask
    initial begin
        reset = 1'b0; ex_br_valid = 1'b1; if_lookup_req = 1'b1; btb_mispred = 1'b0;
        ex_br_res = 1'b0; ex_pc_idx = '0; target_pc = '0;
        repeat (2) step(1, 0, 1, 0);
        step(0, 0, 1);
        step(0, 0, 1);
        step(1, 0, 0);
        ex_pc_idx = 64'h100; ex_br_res = 1'b1; target_pc = 64'h200;
        repeat (2) step(0, 0, 0);
        step(1, 0, 1);
        repeat (12) step(0, 0, 1);
        step(1, 0, 1);
        step(1, 0, 1);
        step(1, 1, 1);
        repeat (6) step(0, 0, 1);
        repeat (5) step(1, 0, 1);
        repeat (8) step(0, 0, 1);
        step(1, 0, 1);
        step(1, 0, 1);
        step(1, 0, 0);
        step(1, 1, 1);
        step(0, 0, 1);
        step(0, 0, 1, 0);
        repeat (3) step(0, 0, 1);
        repeat (3000) step(1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0,
                           $urandom_range(0, 9) < 8, $urandom_range(0, 199) != 0);
        repeat (1000) step(1'($urandom_range(0, 1)), 1'b0, $urandom_range(0, 9) < 9);
        repeat (10) step(0, 0, 0);
        @(negedge clock);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bp_update_sched.md
# bp_update_sched

Arbiter and scheduler for the single-ported branch-predictor tables (BHT/BTB/RAS state behind the predecode branch path). It buffers branch resolutions from execute in a small FIFO and shares the one table port between fetch-side lookups and these updates, one access per cycle. Fetch normally has priority. Updates win when:

- a mispredict is pending,
- the FIFO is full, or
- updates have been starved too long.

## Interface
Parameters:
- DEPTH, 4, update FIFO entries; power of 2, ≥2
- STARVE_MAX, 8, max consecutive cycles a pending update may lose to lookups

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low; state clears on the rising edge of clock while reset==0
- ex_br_valid  in  1  a branch resolution is presented by execute
- ex_pc_idx  in  64  PC of the resolved branch
- ex_br_res  in  1  resolved direction, 1 = taken
- target_pc  in  64  resolved target
- btb_mispred  in  1  resolution was a mispredict; the BTB entry must be written
- ex_stall  out  1  FIFO full; execute holds its resolution
- if_lookup_req  in  1  fetch requests the table port this cycle
- if_lookup_gnt  out  1  fetch owns the port this cycle
- upd_valid  out  1  an update write is issued to the tables this cycle
- upd_pc  out  64  head entry PC
- upd_taken  out  1  head entry direction
- upd_target  out  64  head entry target
- upd_wr_btb  out  1  head entry mispredict flag
- upd_count  out  $clog2(DEPTH+1)  FIFO occupancy

## Operation
FIFO:
- Entry = {pc, taken, target, mispred}.
- Circular buffer with head/tail pointers, wrapping mod DEPTH.
- Enqueue when ex_br_valid && !ex_stall. A resolution presented while ex_stall=1 is ignored; execute re-presents it.
- ex_stall = (count==DEPTH), from registered count. There is no same-cycle enqueue when full, even if a dequeue occurs.
- Dequeue when upd_valid. Simultaneous enqueue and dequeue leaves count unchanged.
- upd_pc / upd_taken / upd_target / upd_wr_btb always show the head entry. They are don't-care when upd_valid=0 but must be held stable.

Counter mp_pend:
- Number of mispred entries in the FIFO.
- +1 on enqueue with btb_mispred; -1 on dequeue with upd_wr_btb.

FSM states, registered, next state computed from next-cycle counts:
- IDLE: count==0. Fetch is granted whenever it requests.
- SHARE: count>0, mp_pend==0, count<DEPTH. Fetch has priority. upd_valid = !if_lookup_req || starve==STARVE_MAX.
- DRAIN: mp_pend>0 or count==DEPTH. upd_valid=1 every cycle; if_lookup_gnt=0.

Grant and starvation:
- Grant rule: if_lookup_gnt = if_lookup_req && !upd_valid. Grant and upd_valid are never both 1.
- starve counter, saturating at STARVE_MAX:
  - increments in SHARE when an update is pending and fetch is granted;
  - clears on any dequeue and in IDLE.
- Transitions:
  - DRAIN→SHARE when mp_pend reaches 0 and count<DEPTH.
  - Any state →IDLE when count reaches 0.

## Timing
- Combinational outputs: ex_stall, if_lookup_gnt, upd_* (all from registered state and if_lookup_req).
- Enqueue latency: an entry accepted at edge N can be written at the earliest in the cycle after N (upd_valid high between edges N and N+1). There is no bypass.
- Worst-case fetch lockout in SHARE: 1 cycle per STARVE_MAX cycles. In DRAIN, lockout lasts until mp_pend==0 and count<DEPTH.
- Reset (reset==0 at an edge), including mid-operation:
  - pointers, count, mp_pend and starve go to 0; state = IDLE; FIFO contents are discarded;
  - while reset==0: upd_valid=0, if_lookup_gnt=0, ex_stall=0.
- Pointer wrap: tail at DEPTH-1 goes to 0 on enqueue; head likewise on dequeue. Order is preserved across the wrap.

## Structure
- Shared package bp_pkg:
  - typedef bp_upd_t {pc[63:0], taken, target[63:0], mispred};
  - enum bp_sched_state_e {IDLE, SHARE, DRAIN};
  - PC width constant 64.
- One natural sub-module: bp_upd_fifo, a parameterized circular FIFO of bp_upd_t with count output.
- The FSM, mp_pend counter and starve counter live in the top module.

## Test plan
- Reset is low 3 cycles with ex_br_valid=1 and if_lookup_req=1 → upd_valid=0, gnt=0, ex_stall=0. After release, count=0, state IDLE, gnt=1.
- Single enqueue (pc=0x100, taken=1, target=0x200, mispred=0) with if_lookup_req=0 → next cycle upd_valid=1 with those values; count returns to 0.
- if_lookup_req held 1; one non-mispredict entry queued with STARVE_MAX=8 → gnt for 8 cycles, then exactly one upd_valid cycle with gnt=0, then gnt resumes.
- Enqueue with btb_mispred=1 behind 2 normal entries while if_lookup_req=1 → DRAIN: 3 consecutive upd_valid cycles in FIFO order with upd_wr_btb on the 3rd, gnt=0 throughout, then IDLE.
- With if_lookup_req=1, enqueue 4 entries on 4 consecutive cycles → ex_stall=1 after the 4th; a 5th ex_br_valid is ignored; DRAIN drains all 4 with correct order across the pointer wrap.
- With count=2, enqueue and dequeue in the same cycle → count stays 2. Assert reset for one cycle mid-drain → count=0, upd_valid=0 next cycle.
